// File: rtl/dmem_resp.sv
// Word-organised data-memory responder for the load/store bus.
// One request is accepted at a time. It is held for a fixed number of wait
// states and then answered. Stores are merged into the word by byte lane.
// Misaligned or out-of-range requests are answered with resp_err set.
module dmem_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam bit         NO_WAIT   = (WAIT == 0);
    localparam logic [3:0] WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // A request is bad if it is not word aligned or lies above the array.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (|addr[31:ADDR_W+2]);
    endfunction

    // Replace only the enabled byte lanes of a stored word.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              we_r;
    logic [ADDR_W-1:0] idx_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;
    logic              err_r;
    logic [31:0]       mem_r [DEPTH];

    logic              cur_we_s;
    logic [ADDR_W-1:0] cur_idx_s;
    logic [31:0]       cur_wdata_s;
    logic [3:0]        cur_be_s;
    logic              cur_err_s;
    logic              enter_resp_s;
    logic              write_en_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       resp_data_s;

    // Select the request being served and detect the edge that enters RESP.
    // With no wait states the live bus fields are used, because that request
    // is accepted and answered on the same edge.
    always_comb begin
        cur_we_s     = we_r;
        cur_idx_s    = idx_r;
        cur_wdata_s  = wdata_r;
        cur_be_s     = be_r;
        cur_err_s    = err_r;
        enter_resp_s = 1'b0;
        if (state_r == ST_IDLE) begin
            cur_we_s     = req_we;
            cur_idx_s    = req_addr[ADDR_W+1:2];
            cur_wdata_s  = req_wdata;
            cur_be_s     = req_be;
            cur_err_s    = addr_err(req_addr);
            enter_resp_s = req_valid && NO_WAIT;
        end else if (state_r == ST_BUSY) begin
            enter_resp_s = (cnt_r == 4'd0);
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    assign write_en_s  = enter_resp_s && cur_we_s && !cur_err_s;
    assign rd_word_s   = mem_r[cur_idx_s];
    assign resp_data_s = (cur_we_s || cur_err_s) ? 32'd0 : rd_word_s;

    // Memory array: a store commits on the edge that enters RESP. The array is
    // deliberately not reset, so a committed store survives a reset.
    always_ff @(posedge clk) begin
        if (write_en_s) begin
            mem_r[cur_idx_s] <= lane_merge(mem_r[cur_idx_s], cur_wdata_s, cur_be_s);
        end
    end

    // Handshake FSM with registered outputs and the request capture registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            we_r       <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'd0;
            be_r       <= 4'd0;
            err_r      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        idx_r     <= req_addr[ADDR_W+1:2];
                        wdata_r   <= req_wdata;
                        be_r      <= req_be;
                        err_r     <= addr_err(req_addr);
                        req_ready <= 1'b0;
                        if (NO_WAIT) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= resp_data_s;
                            resp_err   <= cur_err_s;
                        end else begin
                            state_r <= ST_BUSY;
                            cnt_r   <= WAIT_INIT;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 4'd0) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= resp_data_s;
                        resp_err   <= cur_err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= 4'd0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances (WAIT = 2, 0, 4) checked
// against a word-array reference model kept in the bench.
module tb_dmem_resp;

    localparam int NI = 3;

    logic        clk;
    logic        reset;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [31:0] req_addr   [NI];
    logic [31:0] req_wdata  [NI];
    logic [3:0]  req_be     [NI];
    logic        resp_valid [NI];
    logic        resp_ready [NI];
    logic [31:0] resp_rdata [NI];
    logic        resp_err   [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_resp #(
            .ADDR_W(10),
            .WAIT  (g == 0 ? 2 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_be    (req_be[g]),
            .resp_valid(resp_valid[g]),
            .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g])
        );
    end

    int          vec_cnt = 0;
    int          err_cnt = 0;
    time         last_accept;
    bit   [31:0] model_mem [NI][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 4);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int k, input string tag);
        check_val({tag, "_req_ready"},  32'(req_ready[k]),  32'd1);
        check_val({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
        check_val({tag, "_resp_rdata"}, resp_rdata[k],      32'd0);
        check_val({tag, "_resp_err"},   32'(resp_err[k]),   32'd0);
    endtask

    // One complete transaction on instance k; called and returns at a negedge.
    task automatic do_req(input int k, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int hold);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          idx;
        int          cyc;
        bit          seen;
        cyc = 0;
        while (req_ready[k] !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val("ready_before_req", 32'(req_ready[k]), 32'd1);
        exp_err = (addr[1:0] != 2'd0) || (addr >= 32'h0000_1000);
        idx     = int'(addr[11:2]);
        exp_rd  = (we || exp_err) ? 32'd0 : model_mem[k][idx];
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        @(posedge clk);
        last_accept = $time;
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_we[k]    = 1'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_be[k]    = 4'($urandom);
        if (we && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) model_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 50) begin
            if (resp_valid[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            check_val("busy_ready_low", 32'(req_ready[k]), 32'd0);
            resp_ready[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        check_val("resp_timeout", 32'(seen), 32'd1);
        check_val("latency", 32'(cyc), 32'(wait_of(k) + 1));
        check_val("rdata", resp_rdata[k], exp_rd);
        check_val("err", 32'(resp_err[k]), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            resp_ready[k] = 1'b0;
            @(negedge clk);
            check_val("hold_valid", 32'(resp_valid[k]), 32'd1);
            check_val("hold_ready_low", 32'(req_ready[k]), 32'd0);
            check_val("hold_rdata", resp_rdata[k], exp_rd);
            check_val("hold_err", 32'(resp_err[k]), 32'(exp_err));
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        check_val("done_valid_low", 32'(resp_valid[k]), 32'd0);
        check_val("done_ready_high", 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        time         t1;
        logic [31:0] addr;
        int          r;
        for (int k = 0; k < NI; k++) begin
            req_valid[k]  = 1'b0;
            req_we[k]     = 1'b0;
            req_addr[k]   = 32'd0;
            req_wdata[k]  = 32'd0;
            req_be[k]     = 4'd0;
            resp_ready[k] = 1'b0;
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) check_reset_outputs(k, "in_reset");
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) check_reset_outputs(k, "after_reset");

        // WAIT=2: full store, readback, byte-lane merge, errors, backpressure.
        do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 0);
        do_req(0, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 0);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 0);
        do_req(0, 1'b0, 32'h0000_0012, 32'h0,         4'hF, 0);
        do_req(0, 1'b1, 32'h0000_0000, 32'hA5A5_0F0F, 4'hF, 0);
        do_req(0, 1'b1, 32'h0000_1000, 32'h5555_AAAA, 4'hF, 0);
        do_req(0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 0);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 5);
        do_req(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 0);
        do_req(0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 0);

        // WAIT=0: back-to-back loads, one accepted every 2 cycles.
        do_req(1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0);
        do_req(1, 1'b1, 32'h0000_0044, 32'h1357_9BDF, 4'hF, 0);
        do_req(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);
        t1 = last_accept;
        do_req(1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 0);
        check_val("b2b_spacing", 32'(last_accept - t1), 32'd20);
        t1 = last_accept;
        do_req(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);
        check_val("b2b_spacing2", 32'(last_accept - t1), 32'd20);

        // Randomized traffic on every instance over a small initialised window.
        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++) do_req(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                end else if (r == 1) begin
                    addr = $urandom | 32'h0000_1000;
                end else begin
                    addr = 32'($urandom_range(0, 15) * 4);
                end
                do_req(k, 1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3));
            end
        end

        // WAIT=4: reset during BUSY discards an uncommitted store.
        do_req(2, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 32'h0000_0020;
        req_wdata[2] = 32'hCAFE_F00D;
        req_be[2]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check_val("mid_busy_ready_low", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs(2, "async_reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs(2, "post_mid_reset");
        do_req(2, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Word-organised data-memory responder on the load/store bus driven by the processor datapath.
- Sits at the far end of the bus from the datapath. Accepts one request at a time through a valid/ready handshake.
- Applies a programmable number of wait states, commits byte-masked writes, and returns read data with an error flag.
- Lets the core be tested against non-zero memory latency.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words, byte range 0 .. 4*2**ADDR_W-1.
- WAIT, 2, wait-state cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i selects byte lane [8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  load data; 0 for stores and errors
- resp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Memory array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, capture we/addr/wdata/be and evaluate the error condition.
  - If WAIT=0, go to RESP; otherwise go to BUSY with counter=WAIT-1.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle; at counter=0 go to RESP.
- Commit and read timing:
  - A store commits on the edge that enters RESP, writing only the enabled lanes.
  - A load samples the array on that same edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready=1, go to IDLE; resp_valid=0 and req_ready=1 from the next cycle.
  - resp_ready is ignored whenever resp_valid=0.
- Latency:
  - resp_valid rises WAIT+1 cycles after the accept edge.
  - Best-case throughput is one request per WAIT+2 cycles.
- Error condition: req_addr[1:0]!=0, or any of req_addr[31:ADDR_W+2] set.
  - On error, the store is suppressed and resp_rdata=0.
  - Latency is unchanged.
- Store with req_be=4'b0000 is legal: no lane is modified and resp_err=0.
- Load ignores req_be and returns the full word.
- Read-after-write: a load accepted after a store's response completes returns the stored data. Only one request is ever outstanding, so no hazard arises.
- Address decode uses word index req_addr[ADDR_W+1:2]; there is no wrap-around.
- Reset mid-operation:
  - A store not yet committed (reset asserted before the RESP entry edge) is discarded.
  - A store already committed stays in memory.
  - Outputs return to their reset values immediately.
- Request inputs are don't-care outside IDLE; the requester must hold them only until the accept edge.

Test Plan:
- WAIT=2, store addr 0x0000_0010, wdata 0xDEADBEEF, be=4'hF, then load 0x10:
  - store response: resp_valid 3 cycles after accept, rdata=0, err=0;
  - load returns 0xDEADBEEF.
- Byte-enable merge, after the first test: store 0x10 with wdata 0x11223344, be=4'b0101, then load 0x10 -> 0xDE22BE44.
- Errors (ADDR_W=10):
  - load 0x0000_0012 -> err=1, rdata=0;
  - store 0x0000_1000 -> err=1, and the word at 0x0 is unchanged on readback.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid:
  - rdata/err stay stable and req_ready stays 0;
  - on resp_ready=1, req_ready=1 on the next cycle.
- WAIT=0, back-to-back loads: resp_valid one cycle after each accept, with one accepted request per 2 cycles.
- Reset mid-operation, WAIT=4: pulse reset low during BUSY of a store of 0xCAFEF00D to 0x20:
  - outputs go to reset values asynchronously;
  - a subsequent load of 0x20 returns the prior contents, not 0xCAFEF00D.
